// File: rtl/cpu_defs.sv
// Shared core-wide definitions used by fetch, hazard-detection and decode.
package cpu_defs;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC  = 32'h0000_0000;
    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_INC    = 32'd4;

    typedef struct packed {
        word_t instr;
        word_t pcPlus4;
        logic  valid;
    } ifid_t;

    function automatic word_t alignPc(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and stall/flush counters.
module fetch_stage
    import cpu_defs::*;
#(
    parameter word_t RESET_PC  = cpu_defs::RESET_PC,
    parameter word_t NOP_INSTR = cpu_defs::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] idInstr,
    output logic [31:0] idPcPlus4,
    output logic        idValid,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
);

    word_t pc;
    word_t pcPlus4;
    ifid_t ifid;
    logic  flushEn;

    assign pcPlus4 = pc + PC_INC;
    // A redirect arriving while stalled is dropped; ID re-resolves it later.
    assign flushEn = redirect & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_PC;
            ifid <= '{instr: NOP_INSTR, pcPlus4: '0, valid: 1'b0};
        end else if (!stall) begin
            if (redirect) begin
                pc   <= alignPc(redirectTarget);
                ifid <= '{instr: NOP_INSTR, pcPlus4: '0, valid: 1'b0};
            end else begin
                pc   <= pcPlus4;
                ifid <= '{instr: imemData, pcPlus4: pcPlus4, valid: 1'b1};
            end
        end
    end

    assign imemAddr  = pc;
    assign idInstr   = ifid.instr;
    assign idPcPlus4 = ifid.pcPlus4;
    assign idValid   = ifid.valid;

    sat_counter #(.WIDTH(WORD_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall),
        .count (stallCount)
    );

    sat_counter #(.WIDTH(WORD_W)) uFlushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flushEn),
        .count (flushCount)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed literal checks plus randomized run vs. a reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] idInstr;
    logic [31:0] idPcPlus4;
    logic        idValid;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    int tests = 0;
    int fails = 0;
    logic checkEn = 1'b0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .imemAddr       (imemAddr),
        .imemData       (imemData),
        .idInstr        (idInstr),
        .idPcPlus4      (idPcPlus4),
        .idValid        (idValid),
        .stallCount     (stallCount),
        .flushCount     (flushCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign imemData = mem(imemAddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural meaning of each cycle, kept as plain values.
    logic [31:0] mPc, mInstr, mPcPlus4;
    logic        mValid;
    longint      mStalls, mFlushes;

    task automatic modelReset();
        mPc = 32'h0; mInstr = 32'h0; mPcPlus4 = 32'h0; mValid = 1'b0;
        mStalls = 0; mFlushes = 0;
    endtask

    always @(negedge rst_n) modelReset();

    always @(posedge clk) begin
        if (!rst_n) begin
            modelReset();
        end else if (stall) begin
            mStalls = (mStalls >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mStalls + 1;
        end else if (redirect) begin
            mPc = {redirectTarget[31:2], 2'b00};
            mInstr = 32'h0; mPcPlus4 = 32'h0; mValid = 1'b0;
            mFlushes = (mFlushes >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mFlushes + 1;
        end else begin
            mInstr = mem(mPc);
            mPc = mPc + 32'd4;
            mPcPlus4 = mPc;
            mValid = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("imemAddr",   imemAddr,        mPc);
            check("idInstr",    idInstr,         mInstr);
            check("idPcPlus4",  idPcPlus4,       mPcPlus4);
            check("idValid",    {31'b0, idValid}, {31'b0, mValid});
            check("stallCount", stallCount,      mStalls[31:0]);
            check("flushCount", flushCount,      mFlushes[31:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t);
        stall = s; redirect = r; redirectTarget = t;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        #12;
        check("rst_imemAddr",   imemAddr,   32'h0);
        check("rst_idInstr",    idInstr,    32'h0);
        check("rst_idPcPlus4",  idPcPlus4,  32'h0);
        check("rst_idValid",    {31'b0, idValid}, 32'h0);
        check("rst_stallCount", stallCount, 32'h0);
        check("rst_flushCount", flushCount, 32'h0);
        rst_n = 1'b1;
        checkEn = 1'b1;

        tick();
        check("f1_imemAddr",  imemAddr,  32'h4);
        check("f1_idInstr",   idInstr,   mem(32'h0));
        check("f1_idPcPlus4", idPcPlus4, 32'h4);
        check("f1_idValid",   {31'b0, idValid}, 32'h1);
        tick();
        check("f2_imemAddr",  imemAddr,  32'h8);
        check("f2_idInstr",   idInstr,   mem(32'h4));

        drive(1'b1, 1'b0, 32'h0);
        tick();
        check("s1_imemAddr",  imemAddr,  32'h8);
        check("s1_idInstr",   idInstr,   mem(32'h4));
        tick();
        check("s2_imemAddr",  imemAddr,  32'h8);
        check("s2_stallCount", stallCount, 32'd2);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        check("s3_imemAddr",  imemAddr,  32'hC);
        check("s3_idInstr",   idInstr,   mem(32'h8));
        check("s3_idPcPlus4", idPcPlus4, 32'hC);

        drive(1'b0, 1'b1, 32'h40);
        tick();
        check("r1_idValid",   {31'b0, idValid}, 32'h0);
        check("r1_idInstr",   idInstr,   32'h0);
        check("r1_imemAddr",  imemAddr,  32'h40);
        check("r1_flushCount", flushCount, 32'd1);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        check("r2_idInstr",   idInstr,   mem(32'h40));
        check("r2_idValid",   {31'b0, idValid}, 32'h1);

        drive(1'b1, 1'b1, 32'h80);
        tick();
        check("sr_imemAddr",   imemAddr,   32'h44);
        check("sr_idInstr",    idInstr,    mem(32'h40));
        check("sr_stallCount", stallCount, 32'd3);
        check("sr_flushCount", flushCount, 32'd1);
        drive(1'b0, 1'b1, 32'h80);
        tick();
        check("sr2_imemAddr",   imemAddr,   32'h80);
        check("sr2_flushCount", flushCount, 32'd2);

        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        check("w1_imemAddr", imemAddr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        check("w2_imemAddr",  imemAddr,  32'h0);
        check("w2_idPcPlus4", idPcPlus4, 32'h0);
        check("w2_idInstr",   idInstr,   mem(32'hFFFF_FFFC));
        drive(1'b0, 1'b1, 32'h43);
        tick();
        check("al_imemAddr", imemAddr, 32'h40);

        // Asynchronous reset while a stall is in progress.
        drive(1'b1, 1'b0, 32'h0);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_imemAddr",   imemAddr,   32'h0);
        check("ar_idValid",    {31'b0, idValid}, 32'h0);
        check("ar_idInstr",    idInstr,    32'h0);
        check("ar_stallCount", stallCount, 32'h0);
        check("ar_flushCount", flushCount, 32'h0);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        check("ar2_idInstr",  idInstr,  mem(32'h0));
        check("ar2_idValid",  {31'b0, idValid}, 32'h1);
        check("ar2_imemAddr", imemAddr, 32'h4);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom);
            tick();
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core. It holds the PC and drives the instruction-memory address. It latches the fetched instruction and PC+4 into the IF/ID register for decode. It consumes the load-use `stall` produced by hazard detection and the branch/jump redirect resolved in ID. It also keeps stall and flush event counters for performance debug.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000: instruction word inserted into IF/ID on flush/reset (`sll $0,$0,0`).

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  load-use stall from hazard detection; freeze PC and IF/ID.
- `redirect`  input  1  taken branch/jump resolved in ID this cycle.
- `redirectTarget`  input  32  target PC for `redirect`.
- `imemAddr`  output  32  instruction-memory address (equals current PC).
- `imemData`  input  32  instruction word; combinational read of `imemAddr`, valid same cycle.
- `idInstr`  output  32  IF/ID instruction.
- `idPcPlus4`  output  32  IF/ID PC+4.
- `idValid`  output  1  IF/ID holds a real instruction (0 = bubble).
- `stallCount`  output  32  cycles in which `stall` took effect.
- `flushCount`  output  32  cycles in which `redirect` took effect.

## Operation
- Internal state: `pc`, IF/ID register (`idInstr`, `idPcPlus4`, `idValid`), and two counters.
- `imemAddr = pc`, purely combinational.
- Priority per rising edge: reset > stall > redirect > normal.
- **Stall**: `pc`, `idInstr`, `idPcPlus4` and `idValid` all hold. `stallCount` increments. Any `redirect` in the same cycle is ignored; ID re-resolves the branch on a later cycle.
- **Redirect (no stall)**: `pc <= redirectTarget`, `idInstr <= NOP_INSTR`, `idPcPlus4 <= 0`, `idValid <= 0`. `flushCount` increments.
- **Normal**: `pc <= pc + 4`, `idInstr <= imemData`, `idPcPlus4 <= pc + 4`, `idValid <= 1`.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no error flag.
- Counters are 32-bit and saturate at 32'hFFFF_FFFF; they do not wrap.
- `redirectTarget` low two bits are forced to 0 when loaded into `pc`.

## Timing
- Reset (asynchronous assert, synchronous-style deassert at the next edge): `pc = RESET_PC`, `idInstr = NOP_INSTR`, `idPcPlus4 = 0`, `idValid = 0`, counters = 0. These values apply immediately on `rst_n` low, independent of `clk`.
- Fetch-to-decode latency is 1 cycle: an instruction at PC X is fetched in cycle n and appears on `idInstr` in cycle n+1.
- Redirect penalty is 1 bubble: the edge that takes the redirect inserts the NOP. The target instruction reaches IF/ID one cycle later.
- A stall of k consecutive cycles holds the outputs for exactly k cycles; fetch resumes at the held PC.
- If reset asserts mid-stall or mid-redirect, all state is discarded; the first fetch after release is at `RESET_PC`.
- The first edge after `rst_n` rises fetches `RESET_PC`; `idValid` becomes 1 at that edge.

## Structure
- Shared package (`cpu_defs`): `RESET_PC`, `NOP_INSTR`, `WORD_W = 32`, `PC_INC = 4`, shared with the hazard-detection and decode stages.
- One sub-module: `sat_counter` (32-bit, enable, saturating, async active-low clear). It is instantiated twice, for `stallCount` and `flushCount`.
- The PC register and IF/ID register stay inline in `fetch_stage`.

## Test plan
- Reset with `RESET_PC`=0 and `imemData`=PC-indexed pattern, release reset, run 3 cycles → `imemAddr` 0,4,8; `idInstr`/`idPcPlus4` follow one cycle behind; `idValid`=1 from the first post-reset edge.
- Assert `stall` for 2 cycles at PC=8 → `imemAddr` holds 8 and IF/ID holds the PC=4 instruction for 2 cycles; `stallCount`=2; fetch resumes at 8.
- `redirect`=1 with `redirectTarget`=0x40 at PC=0xC → next cycle `idValid`=0, `idInstr`=NOP, `imemAddr`=0x40, `flushCount`=1; the following cycle `idInstr`=mem[0x40].
- `stall` and `redirect` both 1 → PC and IF/ID hold, `stallCount`+1, `flushCount` unchanged. Dropping `stall` with `redirect` still 1 then redirects normally.
- Set `pc` to 0xFFFF_FFFC via redirect, run 1 cycle → `imemAddr`=0, `idPcPlus4`=0. A `redirectTarget` of 0x43 loads `pc`=0x40.
- Pulse `rst_n` low asynchronously mid-stall → all outputs reach their reset values before the next edge; counters read 0.
